pe_a10_tc2sm: RTL and testbench

PE_A10_TC2SM -- requirements
Module: pe_a10_tc2sm

---
 rtl/pe_a10_tc2sm.sv | 121 ++++++++++++
 tb/tb_pe_a10_tc2sm.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_a10_tc2sm.sv
// Two-stage two's-complement to sign/magnitude converter with magnitude saturation.
// Define PE_TC2SM_SAT_CNT_EN to include the 16-bit saturation event counter.
module pe_a10_tc2sm #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE+1:0] din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic [SIZE-1:0] dout_mag,
    output logic            dout_sign,
    output logic            dout_sat,
    output logic            dout_valid,
    input  logic            dout_ready,
    input  logic            sat_clr,
    output logic [15:0]     sat_count
);
    localparam int W = SIZE + 2;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_sign_q, s1_sign_d;
    logic [W-1:0]    s1_abs_q, s1_abs_d;
    logic            dout_valid_q, dout_valid_d;
    logic            dout_sign_q, dout_sign_d;
    logic            dout_sat_q, dout_sat_d;
    logic [SIZE-1:0] dout_mag_q, dout_mag_d;
    logic            s2_load;
    logic            s1_load;
    logic            s1_sat;

    // Handshake: a word moves across an interface on a rising edge where valid and ready are
    // both 1; a producer holds valid and keeps its data unchanged until the word is taken.
    assign s2_load   = !dout_valid_q || dout_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign din_ready = s1_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_abs_d   = s1_abs_q;
        if (s1_load) begin
            s1_valid_d = din_valid;
            if (din_valid) begin
                s1_sign_d = din[W-1];
                // Full input width keeps |-2^(SIZE+1)| representable as an unsigned value
                s1_abs_d  = din[W-1] ? (~din + W'(1)) : din;
            end
        end
    end

    assign s1_sat = |s1_abs_q[W-1:SIZE];

    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_sign_d  = dout_sign_q;
        dout_sat_d   = dout_sat_q;
        dout_mag_d   = dout_mag_q;
        if (s2_load) begin
            dout_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dout_sign_d = s1_sign_q;
                dout_sat_d  = s1_sat;
                dout_mag_d  = s1_sat ? '1 : s1_abs_q[SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_abs_q     <= '0;
            dout_valid_q <= 1'b0;
            dout_sign_q  <= 1'b0;
            dout_sat_q   <= 1'b0;
            dout_mag_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_abs_q     <= s1_abs_d;
            dout_valid_q <= dout_valid_d;
            dout_sign_q  <= dout_sign_d;
            dout_sat_q   <= dout_sat_d;
            dout_mag_q   <= dout_mag_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_sign  = dout_sign_q;
    assign dout_sat   = dout_sat_q;
    assign dout_mag   = dout_mag_q;

`ifdef PE_TC2SM_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Clear beats a same-cycle increment; the count sticks at all-ones
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (dout_valid_q && dout_ready && dout_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign sat_count      = '0;
`endif
endmodule

// File: tb/tb_pe_a10_tc2sm.sv
// Self-checking bench for pe_a10_tc2sm: directed cases, backpressure, random streaming, reset.
// The counter test follows PE_TC2SM_SAT_CNT_EN the same way the design does.
module tb_pe_a10_tc2sm;
    localparam int SIZE = 4;
    localparam int W    = SIZE + 2;

    logic            clk;
    logic            reset;
    logic [W-1:0]    din;
    logic            din_valid;
    logic            din_ready;
    logic [SIZE-1:0] dout_mag;
    logic            dout_sign;
    logic            dout_sat;
    logic            dout_valid;
    logic            dout_ready;
    logic            sat_clr;
    logic [15:0]     sat_count;

    int vectors;
    int miscompares;

    logic [W-1:0] exp_q[$];

    // Values observed during the most recent cycle() call
    logic         s_ready, s_valid, s_acc, s_del;
    logic [W-1:0] s_out;
    logic [15:0]  s_cnt;

    pe_a10_tc2sm #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_mag   (dout_mag),
        .dout_sign  (dout_sign),
        .dout_sat   (dout_sat),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat_clr    (sat_clr),
        .sat_count  (sat_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Result packed as {sign, sat, mag}, computed from the integer value of the input.
    function automatic logic [W-1:0] ref_word(input logic [W-1:0] d);
        int   v;
        int   a;
        logic sat;
        v   = int'($signed(d));
        a   = (v < 0) ? -v : v;
        sat = (a > (2**SIZE - 1));
        if (sat) a = 2**SIZE - 1;
        return {(v < 0), sat, a[SIZE-1:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic rst, input logic dv, input logic [W-1:0] d,
                         input logic dr, input logic clr);
        @(negedge clk);
        reset      = rst;
        din_valid  = dv;
        din        = d;
        dout_ready = dr;
        sat_clr    = clr;
        #1;
        s_ready = din_ready;
        s_valid = dout_valid;
        s_out   = {dout_sign, dout_sat, dout_mag};
        s_cnt   = sat_count;
        s_acc   = dv && din_ready && !rst;
        s_del   = dout_valid && dr && !rst;
        if (s_acc) exp_q.push_back(ref_word(d));
        @(posedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, W'($urandom), 1'b1, 1'b1);
            if (i > 0) begin
                vectors++;
                if (s_valid !== 1'b0 || s_out !== '0 || s_cnt !== 16'd0) begin
                    miscompares++;
                    $display("FAIL reset_state: valid=%b out=%h cnt=%h expected 0 0 0", s_valid, s_out, s_cnt);
                end
            end
        end
        exp_q.delete();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (s_ready !== 1'b1 || s_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_reset: din_ready=%b dout_valid=%b expected 1 0", s_ready, s_valid);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] tin [6];
        logic [W-1:0] tout[6];
        logic [W-1:0] e;
        tin[0] = W'(-5);  tout[0] = 6'b1_0_0101;
        tin[1] = W'(0);   tout[1] = 6'b0_0_0000;
        tin[2] = W'(20);  tout[2] = 6'b0_1_1111;
        tin[3] = W'(-32); tout[3] = 6'b1_1_1111;
        tin[4] = W'(15);  tout[4] = 6'b0_0_1111;
        tin[5] = W'(-16); tout[5] = 6'b1_1_1111;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, tin[i], 1'b1, 1'b0);
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
            vectors++;
            if (s_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL latency_early[%0d]: dout_valid=%b expected 0", i, s_valid);
            end
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if (s_valid !== 1'b1 || s_out !== tout[i] || e !== tout[i]) begin
                miscompares++;
                $display("FAIL basic[%0d]: valid=%b out=%h expected 1 %h", i, s_valid, s_out, tout[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndel;
        logic [W-1:0] e;
        ndel = 0;
        for (int c = 0; c < 14; c++) begin
            cycle(1'b0, (c < 8), W'($urandom), 1'b1, 1'b0);
            if (c < 8) begin
                vectors++;
                if (s_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready[%0d]: din_ready=%b expected 1", c, s_ready);
                end
            end
            if (c >= 2 && c < 10) begin
                vectors++;
                if (s_del !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_gap[%0d]: dout_valid=%b expected 1", c, s_valid);
                end
            end
            if (s_del) begin
                ndel++;
                vectors++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (s_out !== e) begin
                    miscompares++;
                    $display("FAIL b2b_data[%0d]: out=%h expected %h", c, s_out, e);
                end
            end
        end
        vectors++;
        if (ndel != 8 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: delivered %0d left %0d expected 8 0", ndel, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w[3];
        logic [W-1:0] e;
        int idx;
        int ndel;
        w[0] = W'(3); w[1] = W'(-7); w[2] = W'(9);
        idx  = 0;
        ndel = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, (idx < 3), w[(idx < 3) ? idx : 0], (c >= 4), 1'b0);
            if (s_acc) idx++;
            if (c == 2 || c == 3) begin
                vectors++;
                if (s_ready !== 1'b0 || idx != 2 || s_valid !== 1'b1 || s_out !== 6'b0_0_0011) begin
                    miscompares++;
                    $display("FAIL stall[%0d]: ready=%b accepted=%0d valid=%b out=%h expected 0 2 1 03",
                             c, s_ready, idx, s_valid, s_out);
                end
            end
            if (s_del) begin
                vectors++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (s_out !== e || c != 4 + ndel) begin
                    miscompares++;
                    $display("FAIL release[%0d]: out=%h expected %h at cycle %0d", c, s_out, e, 4 + ndel);
                end
                ndel++;
            end
        end
        vectors++;
        if (ndel != 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL release_count: delivered %0d left %0d expected 3 0", ndel, exp_q.size());
        end
    endtask

    task automatic test_stream();
        int n_acc;
        int cyc;
        logic hold;
        logic [W-1:0] prev_out;
        logic [W-1:0] e;
        logic dr;
        n_acc = 0;
        cyc   = 0;
        hold  = 1'b0;
        prev_out = '0;
        while ((n_acc < 100 || exp_q.size() > 0) && cyc < 3000) begin
            dr = ($urandom_range(0, 2) != 0);
            cycle(1'b0, (n_acc < 100) && ($urandom_range(0, 3) != 0), W'($urandom), dr, 1'b0);
            cyc++;
            if (s_acc) n_acc++;
            if (hold) begin
                vectors++;
                if (s_valid !== 1'b1 || s_out !== prev_out) begin
                    miscompares++;
                    $display("FAIL hold[%0d]: valid=%b out=%h expected 1 %h", cyc, s_valid, s_out, prev_out);
                end
            end
            if (s_del) begin
                vectors++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (s_out !== e) begin
                    miscompares++;
                    $display("FAIL stream[%0d]: out=%h expected %h", cyc, s_out, e);
                end
            end
            hold     = s_valid && !dr;
            prev_out = s_out;
        end
        vectors++;
        if (cyc >= 3000) begin
            miscompares++;
            $display("FAIL stream_timeout: accepted %0d pending %0d after %0d cycles", n_acc, exp_q.size(), cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        logic [W-1:0] e;
        cycle(1'b0, 1'b1, W'(5), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, W'(-3), 1'b0, 1'b0);
        vectors++;
        if (exp_q.size() != 2) begin
            miscompares++;
            $display("FAIL inflight: accepted %0d expected 2", exp_q.size());
        end
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        exp_q.delete();
        cycle(1'b0, 1'b1, W'(11), 1'b1, 1'b0);
        vectors++;
        if (s_valid !== 1'b0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: valid=%b ready=%b expected 0 1", s_valid, s_ready);
        end
        found = 1'b0;
        for (int c = 0; c < 4 && !found; c++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
            if (s_del) begin
                found = 1'b1;
                vectors++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (s_out !== e || s_out !== 6'b0_0_1011) begin
                    miscompares++;
                    $display("FAIL first_after_reset: out=%h expected %h", s_out, e);
                end
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL first_after_reset_timeout: no word delivered within 4 cycles");
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

`ifdef PE_TC2SM_SAT_CNT_EN
    task automatic test_counter();
        logic [W-1:0] e;
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, (c < 3), W'(20), 1'b1, 1'b0);
            if (s_del) begin
                vectors++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (s_out !== e) begin
                    miscompares++;
                    $display("FAIL cnt_data[%0d]: out=%h expected %h", c, s_out, e);
                end
            end
        end
        vectors++;
        if (s_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL cnt_three: sat_count=%0d expected 3", s_cnt);
        end
        cycle(1'b0, 1'b1, W'(-32), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        void'(exp_q.pop_front());
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (s_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL cnt_clr_wins: sat_count=%0d expected 0", s_cnt);
        end
        @(negedge clk);
        dut.sat_cnt_q = 16'hFFFF;
        cycle(1'b0, 1'b1, W'(20), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (s_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL cnt_sticky: sat_count=%h expected ffff", s_cnt);
        end
    endtask
`else
    task automatic test_counter();
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, (c < 4), W'(-32), 1'b1, ($urandom_range(0, 1) == 1));
            vectors++;
            if (s_cnt !== 16'd0) begin
                miscompares++;
                $display("FAIL cnt_tied[%0d]: sat_count=%h expected 0", c, s_cnt);
            end
        end
        exp_q.delete();
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        din         = '0;
        din_valid   = 1'b0;
        dout_ready  = 1'b1;
        sat_clr     = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
